// File: rtl/gpc_4t_pkg.sv
// Shared opcode and request types for the core-to-fabric request path.
package gpc_4t_pkg;

  typedef enum logic [1:0] {
    RD     = 2'b00,
    WR     = 2'b01,
    RD_RSP = 2'b10,
    WR_RSP = 2'b11
  } opcodeT;

  typedef struct packed {
    opcodeT      opcode;
    logic [1:0]  threadID;
    logic [31:0] address;
    logic [31:0] data;
  } reqT;

  function automatic opcodeT rspOpcode(input opcodeT op);
    return (op == WR) ? WR_RSP : RD_RSP;
  endfunction

endpackage

// File: rtl/lotr_c2f_responder_if.sv
// Core <-> responder signal bundle: request in, response out, flow control and errors.
// Handshake: a request is taken on every edge where C2F_ReqValidQ500H=1 (no ready);
// the core must stop issuing while C2F_RspStall=1. Responses are single-cycle
// C2F_RspValidQ502H pulses with no back-pressure; F_RspHoldQnnnH only delays their issue.
interface lotr_c2f_responder_if;
  logic        C2F_ReqValidQ500H;
  logic [1:0]  C2F_ReqOpcodeQ500H;
  logic [1:0]  C2F_ReqThreadIDQ500H;
  logic [31:0] C2F_ReqAddressQ500H;
  logic [31:0] C2F_ReqDataQ500H;
  logic        C2F_RspValidQ502H;
  logic [1:0]  C2F_RspOpcodeQ502H;
  logic [1:0]  C2F_RspThreadIDQ502H;
  logic [31:0] C2F_RspDataQ502H;
  logic        C2F_RspStall;
  logic        F_RspHoldQnnnH;
  logic        ErrAdrsQ502H;
  logic        ErrOvfSticky;

  modport master (
    output C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
           C2F_ReqAddressQ500H, C2F_ReqDataQ500H, F_RspHoldQnnnH,
    input  C2F_RspValidQ502H, C2F_RspOpcodeQ502H, C2F_RspThreadIDQ502H,
           C2F_RspDataQ502H, C2F_RspStall, ErrAdrsQ502H, ErrOvfSticky
  );

  modport slave (
    input  C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
           C2F_ReqAddressQ500H, C2F_ReqDataQ500H, F_RspHoldQnnnH,
    output C2F_RspValidQ502H, C2F_RspOpcodeQ502H, C2F_RspThreadIDQ502H,
           C2F_RspDataQ502H, C2F_RspStall, ErrAdrsQ502H, ErrOvfSticky
  );
endinterface

// File: rtl/lotr_c2f_req_fifo.sv
// Request FIFO with registered head (no bypass); a push while full is accepted
// only when a pop happens in the same cycle.
module lotr_c2f_req_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     push,
  input  T                         pushData,
  input  logic                     pop,
  output T                         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [PW-1:0] wrPtr, rdPtr;
  logic          doPush, doPop;
  T              store [DEPTH];

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = store[rdPtr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (!doPush && doPop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) store[wrPtr] <= pushData;
  end
endmodule

// File: rtl/lotr_c2f_responder.sv
// Local-memory responder: queues core RD/WR requests, serves them from a word
// memory in request order and returns a registered response two cycles later.
module lotr_c2f_responder
  import gpc_4t_pkg::*;
#(
  parameter int          MEM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADRS  = 32'h0040_0000
) (
  input logic                  QClk,
  input logic                  RstQnnnL,
  lotr_c2f_responder_if.slave  c2f
);
  localparam int          AW        = $clog2(MEM_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] WIN_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [CW-1:0] STALL_AT = CW'(FIFO_DEPTH - 1);

  reqT           reqIn, head;
  logic          push, pop, full, empty;
  logic [CW-1:0] count;
  logic [31:0]   offset;
  logic          inWin;
  logic [AW-1:0] wordIdx;
  logic [31:0]   mem [MEM_WORDS];

  logic          rspValid, errAdrs, ovfSticky;
  opcodeT        rspOp;
  logic [1:0]    rspTid;
  logic [31:0]   rspData;

  assign reqIn = '{opcode:   opcodeT'(c2f.C2F_ReqOpcodeQ500H),
                   threadID: c2f.C2F_ReqThreadIDQ500H,
                   address:  c2f.C2F_ReqAddressQ500H,
                   data:     c2f.C2F_ReqDataQ500H};

  // Response opcodes arriving on the request bus are silently ignored.
  assign push = c2f.C2F_ReqValidQ500H && !c2f.C2F_ReqOpcodeQ500H[1];
  assign pop  = !empty && !c2f.F_RspHoldQnnnH;

  lotr_c2f_req_fifo #(.DEPTH(FIFO_DEPTH), .T(reqT)) u_fifo (
    .clk      (QClk),
    .rstN     (RstQnnnL),
    .push     (push),
    .pushData (reqIn),
    .pop      (pop),
    .popData  (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // Addresses below the base wrap to large offsets and fall out of the window.
  assign offset  = head.address - BASE_ADRS;
  assign inWin   = (offset < WIN_BYTES);
  assign wordIdx = offset[AW+1:2];

  always_ff @(posedge QClk) begin
    if (pop && inWin && head.opcode == WR) mem[wordIdx] <= head.data;
  end

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      rspValid  <= 1'b0;
      rspOp     <= RD;
      rspTid    <= '0;
      rspData   <= '0;
      errAdrs   <= 1'b0;
      ovfSticky <= 1'b0;
    end else begin
      rspValid <= pop;
      errAdrs  <= pop && !inWin;
      if (pop) begin
        rspOp   <= rspOpcode(head.opcode);
        rspTid  <= head.threadID;
        rspData <= !inWin ? 32'h0 : ((head.opcode == WR) ? head.data : mem[wordIdx]);
      end
      if (push && full && !pop) ovfSticky <= 1'b1;
    end
  end

  assign c2f.C2F_RspValidQ502H    = rspValid;
  assign c2f.C2F_RspOpcodeQ502H   = rspOp;
  assign c2f.C2F_RspThreadIDQ502H = rspTid;
  assign c2f.C2F_RspDataQ502H     = rspData;
  assign c2f.ErrAdrsQ502H         = errAdrs;
  assign c2f.ErrOvfSticky         = ovfSticky;
  assign c2f.C2F_RspStall         = (count >= STALL_AT);
endmodule

// File: tb/tb_lotr_c2f_responder.sv
// Directed scoreboard bench for lotr_c2f_responder: stimulus pushes expected
// responses, a negedge monitor pops and compares each response pulse.
module tb_lotr_c2f_responder;
  import gpc_4t_pkg::*;

  localparam int W = 37; // {err, opcode, threadID, data}

  logic QClk;
  logic RstQnnnL;
  lotr_c2f_responder_if bus();

  lotr_c2f_responder #(
    .MEM_WORDS  (256),
    .FIFO_DEPTH (4),
    .BASE_ADRS  (32'h0040_0000)
  ) dut (
    .QClk     (QClk),
    .RstQnnnL (RstQnnnL),
    .c2f      (bus.slave)
  );

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rsp_count = 0;

  // clock / reset
  initial QClk = 1'b0;
  always #5 QClk = ~QClk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_req(input logic [1:0] op, input logic [1:0] tid,
                          input logic [31:0] addr, input logic [31:0] data);
    bus.C2F_ReqValidQ500H    = 1'b1;
    bus.C2F_ReqOpcodeQ500H   = op;
    bus.C2F_ReqThreadIDQ500H = tid;
    bus.C2F_ReqAddressQ500H  = addr;
    bus.C2F_ReqDataQ500H     = data;
    @(posedge QClk);
    #1;
    bus.C2F_ReqValidQ500H    = 1'b0;
  endtask

  task automatic exp_rsp(input logic err, input logic [1:0] op, input logic [1:0] tid,
                         input logic [31:0] data);
    exp_q.push_back({err, op, tid, data});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge QClk);
    #1;
  endtask

  task automatic drain(input string name);
    int budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge QClk);
      budget--;
    end
    #1;
    chk({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge QClk) begin
    if (RstQnnnL) begin
      if (bus.C2F_RspValidQ502H) begin
        rsp_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got op=%0d tid=%0d data=%h expected none",
                   bus.C2F_RspOpcodeQ502H, bus.C2F_RspThreadIDQ502H, bus.C2F_RspDataQ502H);
        end else begin
          logic [W-1:0] exp_v;
          logic [W-1:0] got_v;
          exp_v = exp_q.pop_front();
          got_v = {bus.ErrAdrsQ502H, bus.C2F_RspOpcodeQ502H,
                   bus.C2F_RspThreadIDQ502H, bus.C2F_RspDataQ502H};
          if (got_v !== exp_v) begin
            errors++;
            $display("FAIL rsp_compare: got %h expected %h", got_v, exp_v);
          end
        end
      end else begin
        checks++;
        if (bus.ErrAdrsQ502H !== 1'b0) begin
          errors++;
          $display("FAIL err_without_valid: got %b expected 0", bus.ErrAdrsQ502H);
        end
      end
    end
  end

  initial begin
    int base_cnt;
    RstQnnnL = 1'b1;
    bus.C2F_ReqValidQ500H    = 1'b0;
    bus.C2F_ReqOpcodeQ500H   = 2'b00;
    bus.C2F_ReqThreadIDQ500H = 2'b00;
    bus.C2F_ReqAddressQ500H  = 32'h0;
    bus.C2F_ReqDataQ500H     = 32'h0;
    bus.F_RspHoldQnnnH       = 1'b0;
    #2 RstQnnnL = 1'b0;
    #1;
    chk("reset_outputs", 64'({bus.C2F_RspValidQ502H, bus.C2F_RspOpcodeQ502H,
        bus.C2F_RspThreadIDQ502H, bus.C2F_RspDataQ502H, bus.ErrAdrsQ502H,
        bus.ErrOvfSticky}), 64'd0);
    chk("reset_stall", 64'(bus.C2F_RspStall), 64'd0);
    repeat (3) @(negedge QClk);
    RstQnnnL = 1'b1;
    @(posedge QClk);
    #1;
    chk("stall_after_reset", 64'(bus.C2F_RspStall), 64'd0);

    // write then read back, checking two-cycle latency
    exp_rsp(1'b0, WR_RSP, 2'd2, 32'hDEADBEEF);
    exp_rsp(1'b0, RD_RSP, 2'd1, 32'hDEADBEEF);
    send_req(WR, 2'd2, 32'h0040_0010, 32'hDEADBEEF);
    @(negedge QClk);
    chk("latency_cycle1_valid", 64'(bus.C2F_RspValidQ502H), 64'd0);
    send_req(RD, 2'd1, 32'h0040_0010, 32'h0);
    @(negedge QClk);
    chk("latency_cycle2_valid", 64'(bus.C2F_RspValidQ502H), 64'd1);
    drain("wr_rd");

    // ignored bits [1:0] and last in-window word
    exp_rsp(1'b0, RD_RSP, 2'd3, 32'hDEADBEEF);
    exp_rsp(1'b0, WR_RSP, 2'd0, 32'h5A5A5A5A);
    exp_rsp(1'b0, RD_RSP, 2'd0, 32'h5A5A5A5A);
    send_req(RD, 2'd3, 32'h0040_0013, 32'h0);
    send_req(WR, 2'd0, 32'h0040_03FC, 32'h5A5A5A5A);
    send_req(RD, 2'd0, 32'h0040_03FC, 32'h0);
    drain("edge_words");

    // hold with three requests: stall at count 3, no responses
    bus.F_RspHoldQnnnH = 1'b1;
    base_cnt = rsp_count;
    exp_rsp(1'b0, WR_RSP, 2'd0, 32'h11111111);
    exp_rsp(1'b0, RD_RSP, 2'd1, 32'h11111111);
    exp_rsp(1'b0, WR_RSP, 2'd3, 32'h22222222);
    send_req(WR, 2'd0, 32'h0040_0020, 32'h11111111);
    send_req(RD, 2'd1, 32'h0040_0020, 32'h0);
    chk("stall_at_count2", 64'(bus.C2F_RspStall), 64'd0);
    send_req(WR, 2'd3, 32'h0040_0024, 32'h22222222);
    chk("stall_at_count3", 64'(bus.C2F_RspStall), 64'd1);
    wait_cycles(5);
    chk("hold_no_rsp", 64'(rsp_count - base_cnt), 64'd0);
    chk("hold_stall_kept", 64'(bus.C2F_RspStall), 64'd1);
    bus.F_RspHoldQnnnH = 1'b0;
    @(negedge QClk);
    chk("release_first_gap", 64'(bus.C2F_RspValidQ502H), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge QClk);
      chk("release_back_to_back", 64'(bus.C2F_RspValidQ502H), 64'd1);
    end
    @(negedge QClk);
    chk("release_valid_pulse_end", 64'(bus.C2F_RspValidQ502H), 64'd0);
    chk("release_stall_drop", 64'(bus.C2F_RspStall), 64'd0);
    drain("hold");

    // out-of-window accesses leave memory untouched
    exp_rsp(1'b0, WR_RSP, 2'd2, 32'h0BADF00D);
    exp_rsp(1'b1, RD_RSP, 2'd2, 32'h0);
    exp_rsp(1'b1, RD_RSP, 2'd3, 32'h0);
    exp_rsp(1'b1, WR_RSP, 2'd1, 32'h0);
    exp_rsp(1'b0, RD_RSP, 2'd0, 32'h0BADF00D);
    send_req(WR, 2'd2, 32'h0040_0000, 32'h0BADF00D);
    send_req(RD, 2'd2, 32'h0030_0000, 32'h0);
    send_req(RD, 2'd3, 32'h003F_FFFC, 32'h0);
    send_req(WR, 2'd1, 32'h0040_0400, 32'hCAFEF00D);
    send_req(RD, 2'd0, 32'h0040_0000, 32'h0);
    drain("out_of_window");

    // response opcodes on the request bus are ignored
    base_cnt = rsp_count;
    send_req(RD_RSP, 2'd1, 32'h0040_0010, 32'h0);
    send_req(WR_RSP, 2'd1, 32'h0040_0010, 32'h0);
    wait_cycles(4);
    chk("ignored_opcodes", 64'(rsp_count - base_cnt), 64'd0);

    // overflow: five requests under hold, fifth dropped
    chk("ovf_before", 64'(bus.ErrOvfSticky), 64'd0);
    bus.F_RspHoldQnnnH = 1'b1;
    base_cnt = rsp_count;
    exp_rsp(1'b0, RD_RSP, 2'd0, 32'hDEADBEEF);
    exp_rsp(1'b0, RD_RSP, 2'd1, 32'h11111111);
    exp_rsp(1'b0, RD_RSP, 2'd2, 32'h22222222);
    exp_rsp(1'b0, WR_RSP, 2'd3, 32'h33333333);
    send_req(RD, 2'd0, 32'h0040_0010, 32'h0);
    send_req(RD, 2'd1, 32'h0040_0020, 32'h0);
    send_req(RD, 2'd2, 32'h0040_0024, 32'h0);
    send_req(WR, 2'd3, 32'h0040_0030, 32'h33333333);
    chk("ovf_not_yet", 64'(bus.ErrOvfSticky), 64'd0);
    send_req(WR, 2'd0, 32'h0040_0034, 32'h44444444);
    chk("ovf_sticky_set", 64'(bus.ErrOvfSticky), 64'd1);
    wait_cycles(2);
    bus.F_RspHoldQnnnH = 1'b0;
    drain("overflow");
    wait_cycles(4);
    chk("ovf_rsp_count", 64'(rsp_count - base_cnt), 64'd4);
    chk("ovf_sticky_kept", 64'(bus.ErrOvfSticky), 64'd1);
    exp_rsp(1'b0, RD_RSP, 2'd0, 32'h33333333);
    send_req(RD, 2'd0, 32'h0040_0030, 32'h0);
    drain("ovf_readback");

    // reset mid-operation discards queued and in-flight responses
    exp_rsp(1'b0, WR_RSP, 2'd1, 32'h77777777);
    send_req(WR, 2'd1, 32'h0040_0040, 32'h77777777);
    drain("pre_reset_wr");
    send_req(RD, 2'd2, 32'h0040_0040, 32'h0);
    send_req(RD, 2'd3, 32'h0040_0040, 32'h0);
    chk("inflight_before_reset", 64'(bus.C2F_RspValidQ502H), 64'd1);
    #1 RstQnnnL = 1'b0;
    #1;
    chk("mid_reset_outputs", 64'({bus.C2F_RspValidQ502H, bus.C2F_RspOpcodeQ502H,
        bus.C2F_RspThreadIDQ502H, bus.C2F_RspDataQ502H, bus.ErrAdrsQ502H,
        bus.ErrOvfSticky}), 64'd0);
    chk("mid_reset_stall", 64'(bus.C2F_RspStall), 64'd0);
    repeat (2) @(negedge QClk);
    RstQnnnL = 1'b1;
    base_cnt = rsp_count;
    wait_cycles(6);
    chk("post_reset_no_rsp", 64'(rsp_count - base_cnt), 64'd0);
    exp_rsp(1'b0, RD_RSP, 2'd1, 32'h77777777);
    send_req(RD, 2'd1, 32'h0040_0040, 32'h0);
    drain("post_reset_rd");

    // final report
    wait_cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
